fwrisc_wb_arb2: RTL

Two-initiator to one-target Wishbone (classic B4) arbiter placed directly downstream of the fwrisc core's instruction (wbi_) and data (wbd_) initiator ports. It merges them onto a single memory bus (wbm_) so a single-ported SRAM or interconnect can serve the core. Round-robin fairness applies on contention. A bus-watchdog terminates stalled cycles with an error.

---
 rtl/fwrisc_wb_arb2_if.sv | 33 +++
 rtl/fwrisc_wb_arb2.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fwrisc_wb_arb2_if.sv
// fwrisc_wb_arb2_if: Wishbone classic bus bundle shared by the arbiter's two
// upstream initiator ports and its downstream memory port.
//
// Signals:
//   adr, dat_w, sel, we, cyc, stb : initiator -> target request fields
//   dat_r, ack, err               : target -> initiator response fields
// Modports:
//   master : the side that issues cycles (drives request fields)
//   slave  : the side that answers cycles (drives response fields)
interface fwrisc_wb_arb2_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    we;
  logic                    cyc;
  logic                    stb;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic                    ack;
  logic                    err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb,
    output dat_r, ack, err
  );
endinterface

// File: rtl/fwrisc_wb_arb2.sv
// fwrisc_wb_arb2: two-initiator to one-target Wishbone classic arbiter that
// merges the fwrisc instruction (wbi) and data (wbd) initiators onto a single
// memory bus (wbm). Round-robin on contention, one IDLE cycle between grants,
// and a bus watchdog that ends a stalled cycle with an error.
//
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   wbi   : instruction initiator, arbiter acts as its target (slave modport)
//   wbd   : data initiator, arbiter acts as its target (slave modport)
//   wbm   : downstream memory bus, arbiter acts as initiator (master modport)
//
// Parameters:
//   ADDR_WIDTH, DATA_WIDTH : bus widths (sel is DATA_WIDTH/8)
//   TIMEOUT                : stalled strobe cycles before the watchdog error; 0 disables it
module fwrisc_wb_arb2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic             clock,
  input  logic             reset,
  fwrisc_wb_arb2_if.slave  wbi,
  fwrisc_wb_arb2_if.slave  wbd,
  fwrisc_wb_arb2_if.master wbm
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic WD_EN = (TIMEOUT > 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2
  } state_t;

  state_t           state_r;
  logic             last_d_r;   // 1 when the most recent grant went to wbd
  logic [CNT_W-1:0] wd_cnt_r;

  logic                  req_i_s;
  logic                  req_d_s;
  logic                  busy_s;
  logic                  expire_s;
  logic [ADDR_WIDTH-1:0] gnt_adr_s;
  logic [DATA_WIDTH-1:0] gnt_dat_w_s;
  logic [SEL_WIDTH-1:0]  gnt_sel_s;
  logic                  gnt_we_s;
  logic                  gnt_cyc_s;
  logic                  gnt_stb_s;
  logic                  resp_ack_s;
  logic                  resp_err_s;

  // Request decode, selection of the granted initiator's fields and watchdog expiry.
  always_comb begin
    req_i_s     = wbi.cyc & wbi.stb;
    req_d_s     = wbd.cyc & wbd.stb;
    gnt_adr_s   = '0;
    gnt_dat_w_s = '0;
    gnt_sel_s   = '0;
    gnt_we_s    = 1'b0;
    gnt_cyc_s   = 1'b0;
    gnt_stb_s   = 1'b0;
    case (state_r)
      BUS_I: begin
        gnt_adr_s   = wbi.adr;
        gnt_dat_w_s = wbi.dat_w;
        gnt_sel_s   = wbi.sel;
        gnt_we_s    = wbi.we;
        gnt_cyc_s   = wbi.cyc;
        gnt_stb_s   = wbi.stb;
      end
      BUS_D: begin
        gnt_adr_s   = wbd.adr;
        gnt_dat_w_s = wbd.dat_w;
        gnt_sel_s   = wbd.sel;
        gnt_we_s    = wbd.we;
        gnt_cyc_s   = wbd.cyc;
        gnt_stb_s   = wbd.stb;
      end
      default: begin
        gnt_adr_s   = '0;
        gnt_dat_w_s = '0;
        gnt_sel_s   = '0;
        gnt_we_s    = 1'b0;
        gnt_cyc_s   = 1'b0;
        gnt_stb_s   = 1'b0;
      end
    endcase
    busy_s   = (state_r != IDLE);
    // The expiry cycle itself is the one that reports the error upstream.
    expire_s = WD_EN & busy_s & (wd_cnt_r == CNT_MAX);
  end

  // Downstream pass-through and per-initiator response steering.
  always_comb begin
    wbm.adr   = gnt_adr_s;
    wbm.dat_w = gnt_dat_w_s;
    wbm.sel   = gnt_sel_s;
    wbm.we    = gnt_we_s;
    wbm.cyc   = gnt_cyc_s & ~expire_s;
    wbm.stb   = gnt_stb_s & ~expire_s;
    // err wins over a simultaneous ack; anything arriving while IDLE is dropped.
    resp_ack_s = busy_s & wbm.ack & ~wbm.err & ~expire_s;
    resp_err_s = busy_s & (wbm.err | expire_s);
    wbi.ack    = (state_r == BUS_I) ? resp_ack_s : 1'b0;
    wbi.err    = (state_r == BUS_I) ? resp_err_s : 1'b0;
    wbd.ack    = (state_r == BUS_D) ? resp_ack_s : 1'b0;
    wbd.err    = (state_r == BUS_D) ? resp_err_s : 1'b0;
  end

  // Both initiators see the target's read data; only ack/err qualify it.
  assign wbi.dat_r = wbm.dat_r;
  assign wbd.dat_r = wbm.dat_r;

  // Arbitration FSM, round-robin history and watchdog counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      last_d_r <= 1'b1;
      wd_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          wd_cnt_r <= '0;
          if (req_i_s && (!req_d_s || last_d_r)) begin
            state_r  <= BUS_I;
            last_d_r <= 1'b0;
          end else if (req_d_s) begin
            state_r  <= BUS_D;
            last_d_r <= 1'b1;
          end else begin
            state_r  <= IDLE;
          end
        end
        BUS_I, BUS_D: begin
          // Dropping cyc ends the grant (normal end or abort); block
          // transfers that hold cyc keep it.
          if (!gnt_cyc_s || expire_s) begin
            state_r  <= IDLE;
            wd_cnt_r <= '0;
          end else if (wbm.ack || wbm.err) begin
            wd_cnt_r <= '0;
          end else if (WD_EN && gnt_stb_s) begin
            wd_cnt_r <= wd_cnt_r + CNT_W'(1);
          end else begin
            wd_cnt_r <= wd_cnt_r;
          end
        end
        default: begin
          state_r  <= IDLE;
          wd_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule
